// File: rtl/adc_sar_ctrl.sv
// SAR ADC conversion controller: sample phase, WIDTH-step binary search
// driving split positive/negative DAC arrays, conventional or monotonic
// capacitor switching, optional free-run.
// Optional feature: define ADC_SAR_TEST_EN to add test_en/test_data, which
// replace the comparator with a preloaded MSB-first bit pattern.
module adc_sar_ctrl #(
  parameter int WIDTH       = 10,
  parameter int SAMP_CYCLES = 2
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             cont,
  input  logic             comp,
`ifdef ADC_SAR_TEST_EN
  input  logic             test_en,
  input  logic [WIDTH-1:0] test_data,
`endif
  output logic             samp,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] bn,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  localparam logic [3:0]       SAMP_LAST = 4'(SAMP_CYCLES - 1);
  localparam logic [WIDTH-1:0] MSB_ONE   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_sampCnt;
  logic             r_mode;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_bn;
  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] w_bStep;
  logic [WIDTH-1:0] w_bnStep;
  logic             w_comp;
  logic             w_sampEnd;
  logic             w_convEnd;
  logic             w_goSample;

  assign w_sampEnd  = (r_state == SAMPLE) && (r_sampCnt == SAMP_LAST);
  assign w_convEnd  = (r_state == CONVERT) && r_mask[0];
  assign w_goSample = start | cont;

`ifdef ADC_SAR_TEST_EN
  logic             r_useTest;
  logic [WIDTH-1:0] r_testSr;

  // Capture the test pattern as conversion begins and shift it out MSB-first
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_useTest <= 1'b0;
      r_testSr  <= '0;
    end else if (w_sampEnd) begin
      r_useTest <= test_en;
      r_testSr  <= test_data;
    end else if (r_state == CONVERT) begin
      r_testSr  <= {r_testSr[WIDTH-2:0], 1'b0};
    end
  end

  assign w_comp = r_useTest ? r_testSr[WIDTH-1] : comp;
`else
  assign w_comp = comp;
`endif

  // State register; reset aborts any conversion in progress
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state logic and phase outputs
  always_comb begin
    w_stateNext = r_state;
    samp        = 1'b0;
    busy        = 1'b0;
    data_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_goSample) w_stateNext = SAMPLE;
      end
      SAMPLE: begin
        samp = 1'b1;
        busy = 1'b1;
        if (w_sampEnd) w_stateNext = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (r_mask[0]) w_stateNext = DONE;
      end
      DONE: begin
        data_valid  = 1'b1;
        w_stateNext = w_goSample ? SAMPLE : IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Sample-phase length counter, cleared whenever not sampling
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)                            r_sampCnt <= '0;
    else if (r_state == SAMPLE && !w_sampEnd) r_sampCnt <= r_sampCnt + 4'd1;
    else                                   r_sampCnt <= '0;
  end

  // Switching mode is frozen at the moment a conversion is launched
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)
      r_mode <= 1'b0;
    else if ((r_state == IDLE || r_state == DONE) && w_goSample)
      r_mode <= mode;
  end

  // DAC update for the bit selected by r_mask, in either switching scheme
  always_comb begin
    w_bStep  = r_b;
    w_bnStep = r_bn;
    if (r_mode) begin
      if (w_comp) w_bnStep = r_bn & ~r_mask;
      else        w_bStep  = r_b & ~r_mask;
    end else begin
      w_bStep  = (r_b & ~r_mask) | (w_comp ? r_mask : '0) | (r_mask >> 1);
      w_bnStep = ~w_bStep;
    end
  end

  // Bit-walk mask, partial result and DAC arrays; the DAC parks outside CONVERT
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_res  <= '0;
      r_b    <= '0;
      r_bn   <= ALL_ONES;
    end else if (w_sampEnd) begin
      r_mask <= MSB_ONE;
      r_res  <= '0;
      r_b    <= r_mode ? ALL_ONES : MSB_ONE;
      r_bn   <= r_mode ? ALL_ONES : ~MSB_ONE;
    end else if (r_state == CONVERT) begin
      r_mask <= r_mask >> 1;
      r_res  <= {r_res[WIDTH-3:0], w_comp};
      r_b    <= w_convEnd ? '0 : w_bStep;
      r_bn   <= w_convEnd ? ALL_ONES : w_bnStep;
    end else begin
      r_mask <= '0;
      r_b    <= '0;
      r_bn   <= ALL_ONES;
    end
  end

  // Result register is only written when the final bit resolves
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)         r_dataOut <= '0;
    else if (w_convEnd) r_dataOut <= {r_res, w_comp};
  end

  assign b        = r_b;
  assign bn       = r_bn;
  assign data_out = r_dataOut;

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Testbench for adc_sar_ctrl (WIDTH=10, SAMP_CYCLES=2): directed and random
// conversions compared against a bit-level model of the SAR search.
module tb_adc_sar_ctrl;

  localparam int W = 10;
  localparam int S = 2;
  localparam int PERIOD = S + W + 1;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         cont = 1'b0;
  logic         comp = 1'b0;
`ifdef ADC_SAR_TEST_EN
  logic         test_en = 1'b0;
  logic [W-1:0] test_data = '0;
`endif
  logic         samp;
  logic         busy;
  logic         data_valid;
  logic [W-1:0] b;
  logic [W-1:0] bn;
  logic [W-1:0] data_out;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] lastResult = '0;

  always #5 clk = ~clk;

  adc_sar_ctrl #(.WIDTH(W), .SAMP_CYCLES(S)) dut (
    .wb_clk_i  (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .cont      (cont),
    .comp      (comp),
`ifdef ADC_SAR_TEST_EN
    .test_en   (test_en),
    .test_data (test_data),
`endif
    .samp      (samp),
    .b         (b),
    .bn        (bn),
    .busy      (busy),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  // Guard against any hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Positive DAC word after k resolved bits of result res
  function automatic logic [W-1:0] expB(input logic m, input logic [W-1:0] res, input int k);
    logic [W-1:0] v;
    if (!m) begin
      v = '0;
      for (int j = 0; j < k; j++) v[W-1-j] = res[W-1-j];
      if (k < W) v[W-1-k] = 1'b1;
    end else begin
      v = '1;
      for (int j = 0; j < k; j++) if (!res[W-1-j]) v[W-1-j] = 1'b0;
    end
    return v;
  endfunction

  // Negative DAC word after k resolved bits of result res
  function automatic logic [W-1:0] expBn(input logic m, input logic [W-1:0] res, input int k);
    logic [W-1:0] v;
    if (!m) begin
      v = ~expB(m, res, k);
    end else begin
      v = '1;
      for (int j = 0; j < k; j++) if (res[W-1-j]) v[W-1-j] = 1'b0;
    end
    return v;
  endfunction

  // One conversion from IDLE; comparator answers pat MSB-first.
  // abortStep >= 0 pulls reset at that step; disturb pokes start/mode mid-conversion.
  task automatic applyStimulus(input logic m, input logic [W-1:0] pat, input logic disturb,
                               input int abortStep, input logic useTest);
    logic [W-1:0] pb;
    logic [W-1:0] pbn;
    pb  = '0;
    pbn = '0;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_b", 32'(b), 32'd0);
    checkOutput("idle_bn", 32'(bn), 32'(ONES));
    start = 1'b1;
    mode  = m;
`ifdef ADC_SAR_TEST_EN
    test_en   = useTest;
    test_data = pat;
`endif
    for (int c = 1; c <= S; c++) begin
      @(negedge clk);
      start = 1'b0;
      mode  = 1'($urandom);
      checkOutput("samp_high", 32'(samp), 32'd1);
      checkOutput("samp_busy", 32'(busy), 32'd1);
      checkOutput("samp_dv", 32'(data_valid), 32'd0);
      checkOutput("samp_b", 32'(b), 32'd0);
    end
    comp = useTest ? 1'b0 : pat[W-1];
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (k == abortStep) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_samp", 32'(samp), 32'd0);
        checkOutput("abort_dv", 32'(data_valid), 32'd0);
        checkOutput("abort_b", 32'(b), 32'd0);
        checkOutput("abort_bn", 32'(bn), 32'(ONES));
        checkOutput("abort_dout", 32'(data_out), 32'd0);
        lastResult = '0;
        @(negedge clk);
        checkOutput("abort_hold_dv", 32'(data_valid), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      checkOutput("conv_samp", 32'(samp), 32'd0);
      checkOutput("conv_busy", 32'(busy), 32'd1);
      checkOutput("conv_dv", 32'(data_valid), 32'd0);
      checkOutput("conv_b", 32'(b), 32'(expB(m, pat, k)));
      checkOutput("conv_bn", 32'(bn), 32'(expBn(m, pat, k)));
      checkOutput("conv_dout_hold", 32'(data_out), 32'(lastResult));
      if (m && k > 0) begin
        checkOutput("mono_b_rise", 32'(~pb & b), 32'd0);
        checkOutput("mono_bn_rise", 32'(~pbn & bn), 32'd0);
      end
      pb   = b;
      pbn  = bn;
      comp = useTest ? 1'b0 : pat[W-1-k];
      if (disturb && k < W - 1) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("done_dv", 32'(data_valid), 32'd1);
    checkOutput("done_dout", 32'(data_out), 32'(pat));
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_b", 32'(b), 32'd0);
    checkOutput("done_bn", 32'(bn), 32'(ONES));
    lastResult = pat;
`ifdef ADC_SAR_TEST_EN
    test_en = 1'b0;
`endif
    @(negedge clk);
    checkOutput("post_dv", 32'(data_valid), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_dout", 32'(data_out), 32'(lastResult));
  endtask

  // Directed sequence: reset, abort, directed patterns, disturbance, random, free-run
  initial begin
    $display("[TB] adc_sar_ctrl bench start");
    repeat (2) @(negedge clk);
    checkOutput("rst_samp", 32'(samp), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dv", 32'(data_valid), 32'd0);
    checkOutput("rst_b", 32'(b), 32'd0);
    checkOutput("rst_bn", 32'(bn), 32'(ONES));
    checkOutput("rst_dout", 32'(data_out), 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b0, W'($urandom), 1'b0, 5, 1'b0);
    applyStimulus(1'b0, 10'h2CB, 1'b0, -1, 1'b0);
    applyStimulus(1'b1, 10'h2CB, 1'b0, -1, 1'b0);
    applyStimulus(1'b0, W'($urandom), 1'b1, -1, 1'b0);
    applyStimulus(1'b1, W'($urandom), 1'b1, -1, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b0, -1, 1'b0);
    applyStimulus(1'b1, 10'h3FF, 1'b0, -1, 1'b0);
    for (int n = 0; n < 6; n++)
      applyStimulus(1'($urandom), W'($urandom), 1'b0, -1, 1'b0);

    @(negedge clk);
    cont = 1'b1;
    comp = 1'b1;
    mode = 1'($urandom);
    for (int c = 1; c <= 3 * PERIOD; c++) begin
      @(negedge clk);
      mode = 1'($urandom);
      checkOutput("cont_dv", 32'(data_valid), 32'(c % PERIOD == 0));
      checkOutput("cont_busy", 32'(busy), 32'(c % PERIOD != 0));
      checkOutput("cont_samp", 32'(samp), 32'(c % PERIOD >= 1 && c % PERIOD <= S));
      if (c % PERIOD == 0) begin
        checkOutput("cont_dout", 32'(data_out), 32'h3FF);
        lastResult = 10'h3FF;
      end
      if (c == 3 * PERIOD) cont = 1'b0;
    end
    @(negedge clk);
    checkOutput("cont_stop_busy", 32'(busy), 32'd0);
    checkOutput("cont_stop_dout", 32'(data_out), 32'(lastResult));

`ifdef ADC_SAR_TEST_EN
    applyStimulus(1'b0, 10'h155, 1'b0, -1, 1'b1);
    applyStimulus(1'b1, W'($urandom), 1'b0, -1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sar_ctrl.md
ADC_SAR_CTRL -- requirements
Module: adc_sar_ctrl

Interface
REQ-001 Parameter WIDTH, default 10, conversion resolution in bits (legal 4..16).
REQ-002 Parameter SAMP_CYCLES, default 2, sample-phase length in clocks (legal 1..15).
REQ-003 wb_clk_i  input  1  sole clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  conversion request, level-sampled while idle.
REQ-006 mode  input  1  0 = conventional SAR switching, 1 = monotonic switching.
REQ-007 cont  input  1  1 = free-run, next conversion starts without start.
REQ-008 comp  input  1  comparator decision, 1 = input above DAC level.
REQ-009 samp  output  1  high during sample phase (drives sampling switches).
REQ-010 b  output  WIDTH  positive-side DAC control bits.
REQ-011 bn  output  WIDTH  negative-side DAC control bits.
REQ-012 busy  output  1  high in SAMPLE and CONVERT.
REQ-013 data_out  output  WIDTH  last completed result, MSB first resolved.
REQ-014 data_valid  output  1  one-cycle pulse when data_out updates.

Function
REQ-015 FSM states IDLE, SAMPLE, CONVERT, DONE; encoding free.
REQ-016 IDLE -> SAMPLE when start=1 or cont=1; mode latched on this edge, held constant for the conversion.
REQ-017 SAMPLE lasts exactly SAMP_CYCLES clocks (internal counter), samp=1 throughout, then -> CONVERT.
REQ-018 CONVERT lasts exactly WIDTH clocks, step k (k=0..WIDTH-1) resolves bit i=WIDTH-1-k using comp sampled at that step's clock edge.
REQ-019 Conventional entry: b = only MSB set, bn = ~b; step i: b[i] <= comp, b[i-1] <= 1 if i>0; bn always = ~b.
REQ-020 Monotonic entry: b = all ones, bn = all ones; step i: comp=1 clears bn[i], comp=0 clears b[i]; other bits untouched.
REQ-021 Result bit i = comp at step i in both modes; data_out loaded with full result on CONVERT -> DONE edge.
REQ-022 DONE lasts one clock, data_valid=1; then -> SAMPLE if cont=1 or start=1, else -> IDLE.
REQ-023 Latency: start seen at edge 0 -> data_valid high in cycle SAMP_CYCLES+WIDTH+1.
REQ-024 start while busy=1 ignored, no queueing; mode changes mid-conversion ignored.
REQ-025 data_out holds its value through subsequent conversions until the next DONE.
REQ-026 In IDLE and DONE: b = 0, bn = all ones, samp = 0.

Reset
REQ-027 rst_n=0 forces IDLE immediately, regardless of state, including mid-CONVERT.
REQ-028 Reset values: samp=0, busy=0, data_valid=0, b=0, bn=all ones, data_out=0, counters=0, latched mode=0.
REQ-029 Partial conversion aborted by reset produces no data_valid and leaves data_out=0.
REQ-030 First conversion may start on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro ADC_SAR_TEST_EN, when defined, adds inputs test_en (1) and test_data (WIDTH).
REQ-032 With macro: if test_en=1 at SAMPLE -> CONVERT, test_data loads a shift register used MSB-first as comp for each step; comp pin ignored that conversion.
REQ-033 Without macro: test ports absent, comp pin always used, no shift register synthesised.

Verification (WIDTH=10, SAMP_CYCLES=2)
REQ-034 Reset, pulse start, mode=0, comp pattern 1,0,1,1,0,0,1,0,1,1 -> samp high 2 cycles, data_valid in cycle 13, data_out=0x2CB, b ends 0x2CB, bn 0x134.
REQ-035 Same comp pattern, mode=1 -> data_out=0x2CB, final b=0x2CB, bn=0x134, no bit ever 0->1 during CONVERT.
REQ-036 cont=1 held, comp constant 1 -> data_valid every 13 cycles, data_out=0x3FF, busy low only in DONE cycle.
REQ-037 rst_n low at CONVERT step 5 -> next cycle IDLE, b=0, bn=0x3FF, busy=0, no data_valid, data_out=0.
REQ-038 start re-pulsed and mode toggled during CONVERT -> single conversion, result uses original mode, one data_valid.
REQ-039 ADC_SAR_TEST_EN defined, test_en=1, test_data=0x155, comp tied 0 -> data_out=0x155.
